// File: rtl/udma_ptp_ts_arb.sv
// Round-robin arbiter that packs 96-bit PTP timestamps from two sources into
// atomic 4-word records (header + 3 timestamp words) for a uDMA RX channel.
module udma_ptp_ts_arb #(
   parameter int unsigned SEQ_WIDTH = 16,
   parameter logic [3:0]  HDR_TAG   = 4'hA
) (
   input  logic                 sys_clk_i,
   input  logic                 rstn_i,
   input  logic                 en_i,
   input  logic                 clr_i,
   input  logic [95:0]          src0_data_i,
   input  logic                 src0_valid_i,
   output logic                 src0_ready_o,
   input  logic [95:0]          src1_data_i,
   input  logic                 src1_valid_i,
   output logic                 src1_ready_o,
   output logic [31:0]          data_o,
   output logic                 valid_o,
   input  logic                 ready_i,
   output logic                 busy_o,
   output logic [SEQ_WIDTH-1:0] seq0_o,
   output logic [SEQ_WIDTH-1:0] seq1_o
);

   localparam logic [2:0] IDLE = 3'd0;
   localparam logic [2:0] HDR  = 3'd1;
   localparam logic [2:0] W0   = 3'd2;
   localparam logic [2:0] W1   = 3'd3;
   localparam logic [2:0] W2   = 3'd4;

   logic [2:0]           state_q, state_d;
   logic [95:0]          ts_q, ts_d;
   logic                 src_id_q, src_id_d;
   logic [SEQ_WIDTH-1:0] cap_seq_q, cap_seq_d;
   logic [SEQ_WIDTH-1:0] seq0_q, seq0_d;
   logic [SEQ_WIDTH-1:0] seq1_q, seq1_d;
   logic                 last_q, last_d;
   logic                 grant;
   logic                 gnt_id;
   logic [23:0]          seq_ext;

   // Reset term keeps the ready strobes low while rstn_i is asserted.
   always_comb begin
      grant  = rstn_i && (state_q == IDLE) && en_i && !clr_i && (src0_valid_i || src1_valid_i);
      gnt_id = src1_valid_i && (!src0_valid_i || !last_q);
   end

   assign src0_ready_o = grant && !gnt_id;
   assign src1_ready_o = grant && gnt_id;

   always_comb begin
      state_d   = state_q;
      ts_d      = ts_q;
      src_id_d  = src_id_q;
      cap_seq_d = cap_seq_q;
      seq0_d    = seq0_q;
      seq1_d    = seq1_q;
      last_d    = last_q;
      case (state_q)
         IDLE: begin
            if (grant) begin
               state_d   = HDR;
               ts_d      = gnt_id ? src1_data_i : src0_data_i;
               src_id_d  = gnt_id;
               cap_seq_d = gnt_id ? seq1_q : seq0_q;
               last_d    = gnt_id;
               if (gnt_id) seq1_d = seq1_q + 1'b1;
               else        seq0_d = seq0_q + 1'b1;
            end
         end
         HDR:     if (ready_i) state_d = W0;
         W0:      if (ready_i) state_d = W1;
         W1:      if (ready_i) state_d = W2;
         W2:      if (ready_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (clr_i) begin
         state_d = IDLE;
         seq0_d  = '0;
         seq1_d  = '0;
         last_d  = 1'b1;
      end
   end

   always_ff @(posedge sys_clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q   <= IDLE;
         ts_q      <= '0;
         src_id_q  <= 1'b0;
         cap_seq_q <= '0;
         seq0_q    <= '0;
         seq1_q    <= '0;
         last_q    <= 1'b1;
      end else begin
         state_q   <= state_d;
         ts_q      <= ts_d;
         src_id_q  <= src_id_d;
         cap_seq_q <= cap_seq_d;
         seq0_q    <= seq0_d;
         seq1_q    <= seq1_d;
         last_q    <= last_d;
      end
   end

   always_comb begin
      seq_ext                  = '0;
      seq_ext[SEQ_WIDTH-1:0]   = cap_seq_q;
   end

   always_comb begin
      case (state_q)
         HDR:     data_o = {HDR_TAG, 3'b000, src_id_q, seq_ext};
         W0:      data_o = ts_q[31:0];
         W1:      data_o = ts_q[63:32];
         W2:      data_o = ts_q[95:64];
         default: data_o = '0;
      endcase
   end

   assign valid_o = (state_q != IDLE);
   assign busy_o  = (state_q != IDLE);
   assign seq0_o  = seq0_q;
   assign seq1_o  = seq1_q;

endmodule

// File: tb/tb_udma_ptp_ts_arb.sv
// Scoreboard bench for udma_ptp_ts_arb: expected record words are queued on
// each predicted grant and compared against every word the DUT presents.
module tb_udma_ptp_ts_arb;

   logic        sys_clk_i = 1'b0;
   logic        rstn_i;
   logic        en_i, clr_i, ready_i;
   logic [95:0] src0_data_i, src1_data_i;
   logic        src0_valid_i, src1_valid_i;
   logic        src0_ready_o, src1_ready_o;
   logic [31:0] data_o;
   logic        valid_o, busy_o;
   logic [15:0] seq0_o, seq1_o;

   // Second instance with a narrow counter so the wrap is reachable quickly.
   logic        w_en, w_v0, w_v1, w_ready;
   logic        w_r0, w_r1, w_valid, w_busy;
   logic [31:0] w_data;
   logic [3:0]  w_seq0, w_seq1;

   always #5 sys_clk_i = ~sys_clk_i;

   udma_ptp_ts_arb #(.SEQ_WIDTH(16), .HDR_TAG(4'hA)) u_dut (
      .sys_clk_i(sys_clk_i), .rstn_i(rstn_i), .en_i(en_i), .clr_i(clr_i),
      .src0_data_i(src0_data_i), .src0_valid_i(src0_valid_i), .src0_ready_o(src0_ready_o),
      .src1_data_i(src1_data_i), .src1_valid_i(src1_valid_i), .src1_ready_o(src1_ready_o),
      .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i), .busy_o(busy_o),
      .seq0_o(seq0_o), .seq1_o(seq1_o));

   udma_ptp_ts_arb #(.SEQ_WIDTH(4), .HDR_TAG(4'hA)) u_wrap (
      .sys_clk_i(sys_clk_i), .rstn_i(rstn_i), .en_i(w_en), .clr_i(1'b0),
      .src0_data_i(96'h0), .src0_valid_i(w_v0), .src0_ready_o(w_r0),
      .src1_data_i(96'h0000_0033_0000_0022_0000_0011), .src1_valid_i(w_v1), .src1_ready_o(w_r1),
      .data_o(w_data), .valid_o(w_valid), .ready_i(w_ready), .busy_o(w_busy),
      .seq0_o(w_seq0), .seq1_o(w_seq1));

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference model state
   logic [31:0] exp_q[$];
   logic [31:0] hdr_log[$];
   int          words_left;
   logic        m_last;
   logic [15:0] m_seq0, m_seq1;
   logic        busy_e, g_any, g_id;
   logic [95:0] gd;
   event        mon_ev;

   always @(negedge sys_clk_i) begin
      if (!rstn_i) begin
         exp_q.delete();
         words_left = 0;
         m_last = 1'b1;
         m_seq0 = '0;
         m_seq1 = '0;
      end else begin
         busy_e = (words_left != 0);
         g_any  = !busy_e && en_i && !clr_i && (src0_valid_i || src1_valid_i);
         g_id   = src1_valid_i && (!src0_valid_i || !m_last);
         chk("rdy0", {31'b0, src0_ready_o}, {31'b0, g_any && !g_id});
         chk("rdy1", {31'b0, src1_ready_o}, {31'b0, g_any && g_id});
         chk("busy", {31'b0, busy_o}, {31'b0, busy_e});
         chk("valid", {31'b0, valid_o}, {31'b0, busy_e});
         chk("seq0", {16'b0, seq0_o}, {16'b0, m_seq0});
         chk("seq1", {16'b0, seq1_o}, {16'b0, m_seq1});
         if (busy_e) begin
            chk("data", data_o, exp_q[0]);
            if (ready_i) begin
               if (words_left == 4) hdr_log.push_back(data_o);
               void'(exp_q.pop_front());
               words_left--;
            end
         end
         if (clr_i) begin
            exp_q.delete();
            words_left = 0;
            m_last = 1'b1;
            m_seq0 = '0;
            m_seq1 = '0;
         end else if (g_any) begin
            gd = g_id ? src1_data_i : src0_data_i;
            exp_q.push_back({4'hA, 3'b000, g_id, 8'h00, g_id ? m_seq1 : m_seq0});
            exp_q.push_back(gd[31:0]);
            exp_q.push_back(gd[63:32]);
            exp_q.push_back(gd[95:64]);
            if (g_id) m_seq1 = m_seq1 + 16'd1;
            else      m_seq0 = m_seq0 + 16'd1;
            m_last = g_id;
            words_left = 4;
         end
      end
      -> mon_ev;
   end

   // Sources present fresh data after each accepted timestamp.
   initial forever begin
      @(mon_ev);
      if (rstn_i && src0_valid_i && src0_ready_o) begin
         @(posedge sys_clk_i); #1;
         src0_data_i = {$urandom, $urandom, $urandom};
      end
   end

   initial forever begin
      @(mon_ev);
      if (rstn_i && src1_valid_i && src1_ready_o) begin
         @(posedge sys_clk_i); #1;
         src1_data_i = {$urandom, $urandom, $urandom};
      end
   end

   task automatic tick();
      @(posedge sys_clk_i); #1;
   endtask

   task automatic wait_wl(input int n, input string tag);
      int k;
      k = 0;
      while (words_left != n && k < 200) begin
         @(mon_ev);
         k++;
      end
      chk(tag, words_left, n);
   endtask

   logic pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
   int   idx, nh;
   logic [23:0] es;

   initial begin
      rstn_i = 1'b0; en_i = 1'b1; clr_i = 1'b0; ready_i = 1'b1;
      src0_valid_i = 1'b1; src1_valid_i = 1'b1;
      src0_data_i = 96'h0; src1_data_i = 96'h0;
      w_en = 1'b0; w_v0 = 1'b0; w_v1 = 1'b0; w_ready = 1'b1;
      repeat (3) @(negedge sys_clk_i);
      chk("rst_data", data_o, 32'h0);
      chk("rst_valid", {31'b0, valid_o}, 32'h0);
      chk("rst_busy", {31'b0, busy_o}, 32'h0);
      chk("rst_rdy0", {31'b0, src0_ready_o}, 32'h0);
      chk("rst_rdy1", {31'b0, src1_ready_o}, 32'h0);
      chk("rst_seq", {seq1_o, seq0_o}, 32'h0);
      tick();
      src0_valid_i = 1'b0; src1_valid_i = 1'b0;
      rstn_i = 1'b1;

      // Single source-0 record
      tick();
      src0_data_i  = 96'h0000_0003_0000_0002_0000_0001;
      src0_valid_i = 1'b1;
      wait_wl(4, "t1_gnt");
      tick();
      src0_valid_i = 1'b0;
      wait_wl(0, "t1_done");
      chk("t1_hdr", hdr_log[hdr_log.size()-1], 32'hA000_0000);
      chk("t1_seq0", {16'b0, seq0_o}, 32'h1);

      // Both sources saturated after a clear
      tick();
      clr_i = 1'b1;
      tick();
      clr_i = 1'b0;
      hdr_log.delete();
      src0_valid_i = 1'b1; src1_valid_i = 1'b1;
      repeat (24) @(mon_ev);
      chk("t2_nhdr", {31'b0, hdr_log.size() >= 4}, 32'h1);
      chk("t2_h0", hdr_log[0], 32'hA000_0000);
      chk("t2_h1", hdr_log[1], 32'hA100_0000);
      chk("t2_h2", hdr_log[2], 32'hA000_0001);
      chk("t2_h3", hdr_log[3], 32'hA100_0001);

      // Backpressure pattern 1-0-0-1
      for (int i = 0; i < 60; i++) begin
         tick();
         ready_i = pat[i % 4];
      end
      tick();
      ready_i = 1'b1;

      // Enable dropped during W1
      wait_wl(2, "t5_w1");
      tick();
      en_i = 1'b0;
      repeat (12) tick();
      chk("t5_idle", {31'b0, busy_o}, 32'h0);
      en_i = 1'b1;
      repeat (3) tick();
      chk("t5_resume", {31'b0, busy_o}, 32'h1);

      // Clear asserted in W0
      wait_wl(3, "t6_w0");
      tick();
      clr_i = 1'b1;
      @(mon_ev);
      tick();
      clr_i = 1'b0;
      @(mon_ev);
      chk("t6_valid", {31'b0, valid_o}, 32'h0);
      chk("t6_seq", {seq1_o, seq0_o}, 32'h0);
      chk("t6_gnt0", {31'b0, src0_ready_o}, 32'h1);
      chk("t6_gnt1", {31'b0, src1_ready_o}, 32'h0);
      tick();
      src0_valid_i = 1'b0; src1_valid_i = 1'b0;
      wait_wl(0, "t6_done");

      // Sequence wrap on the narrow-counter instance
      tick();
      w_en = 1'b1; w_v1 = 1'b1;
      idx = 0; nh = 0;
      for (int k = 0; k < 200 && nh < 17; k++) begin
         @(negedge sys_clk_i);
         if (w_valid && w_ready) begin
            if (idx % 4 == 0) begin
               es = 24'(nh % 16);
               chk("wrap_hdr", w_data, {4'hA, 3'b000, 1'b1, es});
               if (nh == 15) chk("wrap_seq", {28'b0, w_seq1}, 32'h0);
               nh++;
            end
            idx++;
         end
      end
      chk("wrap_cnt", nh, 17);
      tick();
      w_v1 = 1'b0; w_en = 1'b0;
      repeat (6) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end

endmodule
